// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and constants for the PLL register sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT     = 3'd3,
        LATCH     = 3'd4,
        GAP       = 3'd5,
        FINISH    = 3'd6,
        WAIT_LOCK = 3'd7
    } state_t;

    // Wide enough for any practical CLK_DIV / LE_CYCLES setting.
    typedef logic [15:0] spi_cnt_t;

    localparam int LOCK_STABLE_CYCLES = 4;

endpackage

`default_nettype wire

// File: rtl/pll_spi_tx.sv
// ============================================================================
// Module      : pll_spi_tx
// Description : Serialises one word MSB first on spi_clk/spi_data, then
//               pulses spi_le for LE_CYCLES clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_spi_tx
    import pll_seq_pkg::*;
#(
    parameter int REG_W     = 32,
    parameter int CLK_DIV   = 4,
    parameter int LE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REG_W-1:0] word,
    output logic             busy,
    output logic             shift_done,
    output logic             le_done,
    output logic             spi_clk,
    output logic             spi_data,
    output logic             spi_le
);

    localparam int              c_BW       = $clog2(REG_W);
    localparam logic [1:0]      c_PH_IDLE  = 2'd0;
    localparam logic [1:0]      c_PH_LOW   = 2'd1;
    localparam logic [1:0]      c_PH_HIGH  = 2'd2;
    localparam logic [1:0]      c_PH_LE    = 2'd3;
    localparam spi_cnt_t        c_DIV_LAST = spi_cnt_t'(CLK_DIV - 1);
    localparam spi_cnt_t        c_LE_LAST  = spi_cnt_t'(LE_CYCLES - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(REG_W - 1);

    logic [1:0]       r_phase;
    spi_cnt_t         r_cnt;
    logic [c_BW-1:0]  r_bit;
    logic [REG_W-1:0] r_shift;
    logic             r_spi_clk;
    logic             r_spi_data;
    logic             r_spi_le;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= c_PH_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_spi_clk  <= 1'b0;
            r_spi_data <= 1'b0;
            r_spi_le   <= 1'b0;
        end else begin
            case (r_phase)
                c_PH_IDLE: begin
                    if (start) begin
                        r_shift    <= word;
                        r_spi_data <= word[REG_W-1];
                        r_cnt      <= '0;
                        r_bit      <= '0;
                        r_phase    <= c_PH_LOW;
                    end
                end
                c_PH_LOW: begin
                    if (r_cnt == c_DIV_LAST) begin
                        r_spi_clk <= 1'b1;
                        r_cnt     <= '0;
                        r_phase   <= c_PH_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_PH_HIGH: begin
                    if (r_cnt == c_DIV_LAST) begin
                        r_spi_clk <= 1'b0;
                        r_cnt     <= '0;
                        if (r_bit == c_BIT_LAST) begin
                            r_spi_data <= 1'b0;
                            r_spi_le   <= 1'b1;
                            r_phase    <= c_PH_LE;
                        end else begin
                            // Next bit goes out on the falling edge, a full low phase ahead of its rising edge.
                            r_bit      <= r_bit + 1'b1;
                            r_shift    <= {r_shift[REG_W-2:0], 1'b0};
                            r_spi_data <= r_shift[REG_W-2];
                            r_phase    <= c_PH_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == c_LE_LAST) begin
                        r_spi_le <= 1'b0;
                        r_cnt    <= '0;
                        r_phase  <= c_PH_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy       = (r_phase != c_PH_IDLE);
    assign shift_done = (r_phase == c_PH_HIGH) && (r_cnt == c_DIV_LAST) && (r_bit == c_BIT_LAST);
    assign le_done    = (r_phase == c_PH_LE) && (r_cnt == c_LE_LAST);
    assign spi_clk    = r_spi_clk;
    assign spi_data   = r_spi_data;
    assign spi_le     = r_spi_le;

endmodule

`default_nettype wire

// File: rtl/pll_reg_sequencer.sv
// ============================================================================
// Module      : pll_reg_sequencer
// Description : Shadow register file with dirty tracking, streamed to a PLL
//               over 3-wire SPI. Optional lock wait: PLL_LOCK_WAIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reg_sequencer
    import pll_seq_pkg::*;
#(
    parameter int                          NUM_REGS  = 11,
    parameter int                          REG_W     = 32,
    parameter logic [NUM_REGS*REG_W-1:0]   INIT      = '0,
    parameter int                          CLK_DIV   = 4,
    parameter int                          LE_CYCLES = 4
`ifdef PLL_LOCK_WAIT_EN
    ,
    parameter int                          LOCK_TIMEOUT = 65535
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        reg_wr,
    input  logic [$clog2(NUM_REGS)-1:0] reg_addr,
    input  logic [REG_W-1:0]            reg_wdata,
    input  logic                        load,
    input  logic                        load_dirty_only,
`ifdef PLL_LOCK_WAIT_EN
    input  logic                        lock_det,
    output logic                        lock_timeout,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [NUM_REGS-1:0]         dirty,
    output logic                        spi_clk,
    output logic                        spi_data,
    output logic                        spi_le
);

    localparam int              c_AW       = $clog2(NUM_REGS);
    localparam logic [c_AW-1:0] c_IDX_LAST = c_AW'(NUM_REGS - 1);
    localparam spi_cnt_t        c_DIV_LAST = spi_cnt_t'(CLK_DIV - 1);
`ifdef PLL_LOCK_WAIT_EN
    localparam state_t          c_END_STATE = WAIT_LOCK;
`else
    localparam state_t          c_END_STATE = FINISH;
`endif

    state_t             r_state;
    logic [c_AW-1:0]    r_idx;
    logic               r_mode;
    logic               r_pend;
    logic               r_pend_mode;
    logic               r_busy;
    logic               r_done;
    spi_cnt_t           r_gap;
    logic [REG_W-1:0]   r_shadow [NUM_REGS];
    logic [NUM_REGS-1:0] r_dirty;
`ifdef PLL_LOCK_WAIT_EN
    logic [2:0]         r_lock_cnt;
    logic [31:0]        r_to_cnt;
    logic               r_lock_timeout;
`endif

    logic w_wr_ok;
    logic w_start;
    logic w_tx_busy;
    logic w_shift_done;
    logic w_le_done;

    assign w_wr_ok = reg_wr && (int'(reg_addr) < NUM_REGS);
    assign w_start = (r_state == CAPTURE) && !w_tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_mode      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_mode <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gap       <= '0;
            r_dirty     <= '1;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= INIT[i*REG_W +: REG_W];
            end
`ifdef PLL_LOCK_WAIT_EN
            r_lock_cnt     <= '0;
            r_to_cnt       <= '0;
            r_lock_timeout <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (load && (r_state != IDLE)) begin
                r_pend      <= 1'b1;
                r_pend_mode <= load_dirty_only;
            end

            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_mode  <= load_dirty_only;
                        r_busy  <= 1'b1;
                        r_idx   <= c_IDX_LAST;
                        r_state <= SCAN;
`ifdef PLL_LOCK_WAIT_EN
                        r_lock_timeout <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (!r_mode || r_dirty[r_idx]) begin
                        r_state <= CAPTURE;
                    end else if (r_idx == '0) begin
                        r_state <= c_END_STATE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!w_tx_busy) begin
                        r_dirty[r_idx] <= 1'b0;
                        r_state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_shift_done) begin
                        r_state <= LATCH;
                    end
                end
                LATCH: begin
                    if (w_le_done) begin
                        r_gap   <= '0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap == c_DIV_LAST) begin
                        if (r_idx == '0) begin
                            r_state <= c_END_STATE;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            r_state <= SCAN;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                WAIT_LOCK: begin
`ifdef PLL_LOCK_WAIT_EN
                    if (lock_det && (r_lock_cnt == 3'(LOCK_STABLE_CYCLES - 1))) begin
                        r_lock_cnt <= '0;
                        r_to_cnt   <= '0;
                        r_state    <= FINISH;
                    end else if (r_to_cnt == 32'(LOCK_TIMEOUT - 1)) begin
                        r_lock_timeout <= 1'b1;
                        r_lock_cnt     <= '0;
                        r_to_cnt       <= '0;
                        r_state        <= FINISH;
                    end else begin
                        r_to_cnt   <= r_to_cnt + 1'b1;
                        r_lock_cnt <= lock_det ? r_lock_cnt + 1'b1 : 3'd0;
                    end
`else
                    r_state <= FINISH;
`endif
                end
                FINISH: begin
                    r_done <= 1'b1;
                    if (r_pend || load) begin
                        // A queued load restarts immediately so busy never drops between passes.
                        r_pend  <= 1'b0;
                        r_mode  <= load ? load_dirty_only : r_pend_mode;
                        r_idx   <= c_IDX_LAST;
                        r_state <= SCAN;
`ifdef PLL_LOCK_WAIT_EN
                        r_lock_timeout <= 1'b0;
`endif
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Placed after the FSM so a write to the word being captured keeps it dirty.
            if (w_wr_ok) begin
                r_shadow[reg_addr] <= reg_wdata;
                r_dirty[reg_addr]  <= 1'b1;
            end
        end
    end

    pll_spi_tx #(
        .REG_W     (REG_W),
        .CLK_DIV   (CLK_DIV),
        .LE_CYCLES (LE_CYCLES)
    ) u_spi_tx (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .word       (r_shadow[r_idx]),
        .busy       (w_tx_busy),
        .shift_done (w_shift_done),
        .le_done    (w_le_done),
        .spi_clk    (spi_clk),
        .spi_data   (spi_data),
        .spi_le     (spi_le)
    );

    assign busy  = r_busy;
    assign done  = r_done;
    assign dirty = r_dirty;
`ifdef PLL_LOCK_WAIT_EN
    assign lock_timeout = r_lock_timeout;
`endif

endmodule

`default_nettype wire
